// File: rtl/int_issue_queue.sv
// Integer issue queue: holds dispatched ALU ops, snoops the CDB for missing operands,
// and hands the oldest ready op to the integer execution unit one cycle after a grant.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_en,
    input  logic [OP_W-1:0]  dispatch_op,
    input  logic [TAG_W-1:0] dispatch_rd_tag,
    input  logic             dispatch_rs1_v,
    input  logic [XLEN-1:0]  dispatch_rs1,
    input  logic             dispatch_rs2_v,
    input  logic [XLEN-1:0]  dispatch_rs2,
    output logic             queue_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             ready_int,
    input  logic             issue_int,
    output logic             exec_valid,
    output logic [OP_W-1:0]  exec_op,
    output logic [XLEN-1:0]  exec_rs1,
    output logic [XLEN-1:0]  exec_rs2,
    output logic [TAG_W-1:0] exec_rd_tag
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] rd_tag;
        logic             rs1_v;
        logic [XLEN-1:0]  rs1;
        logic             rs2_v;
        logic [XLEN-1:0]  rs2;
    } entry_t;

    entry_t           q      [DEPTH];
    entry_t           woken  [DEPTH];
    entry_t           q_next [DEPTH];
    entry_t           disp;
    logic [DEPTH-1:0] rdy;
    logic [IDX_W-1:0] sel;
    logic [CNT_W-1:0] cnt_after;
    logic             do_issue;
    logic             do_dispatch;

    // Valid entries are always packed at the bottom, so the top slot alone tells fullness.
    assign queue_full  = q[DEPTH-1].valid;
    assign ready_int   = |rdy;
    assign do_issue    = issue_int & ready_int;
    assign do_dispatch = dispatch_en & ~queue_full;

    always_comb begin
        rdy = '0;
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = q[i].valid & q[i].rs1_v & q[i].rs2_v;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) sel = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            if (cdb_valid && q[i].valid) begin
                if (!q[i].rs1_v && q[i].rs1[TAG_W-1:0] == cdb_tag) begin
                    woken[i].rs1_v = 1'b1;
                    woken[i].rs1   = cdb_data;
                end
                if (!q[i].rs2_v && q[i].rs2[TAG_W-1:0] == cdb_tag) begin
                    woken[i].rs2_v = 1'b1;
                    woken[i].rs2   = cdb_data;
                end
            end
        end
    end

    // Incoming op can catch a broadcast of its producer in the same cycle.
    always_comb begin
        disp.valid  = 1'b1;
        disp.op     = dispatch_op;
        disp.rd_tag = dispatch_rd_tag;
        disp.rs1_v  = dispatch_rs1_v;
        disp.rs1    = dispatch_rs1;
        disp.rs2_v  = dispatch_rs2_v;
        disp.rs2    = dispatch_rs2;
        if (cdb_valid && !dispatch_rs1_v && dispatch_rs1[TAG_W-1:0] == cdb_tag) begin
            disp.rs1_v = 1'b1;
            disp.rs1   = cdb_data;
        end
        if (cdb_valid && !dispatch_rs2_v && dispatch_rs2[TAG_W-1:0] == cdb_tag) begin
            disp.rs2_v = 1'b1;
            disp.rs2   = cdb_data;
        end
    end

    always_comb begin
        cnt_after = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && i >= int'(sel)) q_next[i] = woken[i+1];
            else                            q_next[i] = woken[i];
        end
        if (do_issue) q_next[DEPTH-1] = '0;
        else          q_next[DEPTH-1] = woken[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            cnt_after = cnt_after + CNT_W'(q_next[i].valid);
        end
        // Append after compaction so a same-cycle issue and dispatch keep age order.
        for (int i = 0; i < DEPTH; i++) begin
            if (do_dispatch && cnt_after == CNT_W'(i)) q_next[i] = disp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            exec_valid  <= 1'b0;
            exec_op     <= '0;
            exec_rs1    <= '0;
            exec_rs2    <= '0;
            exec_rd_tag <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_next[i];
            exec_valid <= do_issue;
            if (do_issue) begin
                exec_op     <= q[sel].op;
                exec_rs1    <= q[sel].rs1;
                exec_rs2    <= q[sel].rs2;
                exec_rd_tag <= q[sel].rd_tag;
            end
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed plus randomized bench for int_issue_queue against an age-ordered list model.
module tb_int_issue_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int OP_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dispatch_en = 1'b0;
    logic [OP_W-1:0]  dispatch_op = '0;
    logic [TAG_W-1:0] dispatch_rd_tag = '0;
    logic             dispatch_rs1_v = 1'b0;
    logic [XLEN-1:0]  dispatch_rs1 = '0;
    logic             dispatch_rs2_v = 1'b0;
    logic [XLEN-1:0]  dispatch_rs2 = '0;
    logic             queue_full;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [XLEN-1:0]  cdb_data = '0;
    logic             ready_int;
    logic             issue_int = 1'b0;
    logic             exec_valid;
    logic [OP_W-1:0]  exec_op;
    logic [XLEN-1:0]  exec_rs1;
    logic [XLEN-1:0]  exec_rs2;
    logic [TAG_W-1:0] exec_rd_tag;

    always #5 clk = ~clk;

    int_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .dispatch_en(dispatch_en), .dispatch_op(dispatch_op), .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_rs1_v(dispatch_rs1_v), .dispatch_rs1(dispatch_rs1),
        .dispatch_rs2_v(dispatch_rs2_v), .dispatch_rs2(dispatch_rs2),
        .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ready_int(ready_int), .issue_int(issue_int), .exec_valid(exec_valid), .exec_op(exec_op),
        .exec_rs1(exec_rs1), .exec_rs2(exec_rs2), .exec_rd_tag(exec_rd_tag)
    );

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] rd;
        bit               v1;
        logic [XLEN-1:0]  s1;
        bit               v2;
        logic [XLEN-1:0]  s2;
    } ent_t;

    ent_t             m_q[$];
    bit               ev = 1'b0;
    logic [OP_W-1:0]  eop = '0;
    logic [XLEN-1:0]  e1 = '0, e2 = '0;
    logic [TAG_W-1:0] erd = '0;
    int               checks = 0;
    int               failures = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // One clock: drive, check outputs against the model, then advance the model.
    task automatic step(bit en, logic [OP_W-1:0] op, logic [TAG_W-1:0] rd,
                        bit v1, logic [XLEN-1:0] s1, bit v2, logic [XLEN-1:0] s2,
                        bit cv, logic [TAG_W-1:0] ct, logic [XLEN-1:0] cd, bit iss);
        int   sel;
        bit   full;
        ent_t n;
        dispatch_en = en; dispatch_op = op; dispatch_rd_tag = rd;
        dispatch_rs1_v = v1; dispatch_rs1 = s1; dispatch_rs2_v = v2; dispatch_rs2 = s2;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd; issue_int = iss;
        #1;
        full = (m_q.size() == DEPTH);
        sel = -1;
        foreach (m_q[i]) if (sel < 0 && m_q[i].v1 && m_q[i].v2) sel = i;
        chk("queue_full", 32'(queue_full), 32'(full));
        chk("ready_int", 32'(ready_int), 32'(sel >= 0));
        chk("exec_valid", 32'(exec_valid), 32'(ev));
        if (ev) begin
            chk("exec_op", 32'(exec_op), 32'(eop));
            chk("exec_rs1", exec_rs1, e1);
            chk("exec_rs2", exec_rs2, e2);
            chk("exec_rd_tag", 32'(exec_rd_tag), 32'(erd));
        end
        ev = iss && (sel >= 0);
        if (ev) begin
            eop = m_q[sel].op; e1 = m_q[sel].s1; e2 = m_q[sel].s2; erd = m_q[sel].rd;
            m_q.delete(sel);
        end
        if (cv) foreach (m_q[i]) begin
            if (!m_q[i].v1 && m_q[i].s1[TAG_W-1:0] == ct) begin m_q[i].v1 = 1'b1; m_q[i].s1 = cd; end
            if (!m_q[i].v2 && m_q[i].s2[TAG_W-1:0] == ct) begin m_q[i].v2 = 1'b1; m_q[i].s2 = cd; end
        end
        if (en && !full) begin
            n.op = op; n.rd = rd; n.v1 = v1; n.s1 = s1; n.v2 = v2; n.s2 = s2;
            if (cv && !v1 && s1[TAG_W-1:0] == ct) begin n.v1 = 1'b1; n.s1 = cd; end
            if (cv && !v2 && s2[TAG_W-1:0] == ct) begin n.v2 = 1'b1; n.s2 = cd; end
            m_q.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(bit iss);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, iss);
    endtask

    task automatic disp_rdy(logic [TAG_W-1:0] rd, bit iss);
        step(1'b1, 4'h1, rd, 1'b1, 32'(rd) + 32'h100, 1'b1, 32'h7, 1'b0, '0, '0, iss);
    endtask

    initial begin
        logic [TAG_W-1:0] order [4];
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_exec_op", 32'(exec_op), 32'h0);
        chk("rst_exec_rs1", exec_rs1, 32'h0);
        chk("rst_exec_rd", 32'(exec_rd_tag), 32'h0);
        idle(1'b1);

        // Basic dispatch and issue
        step(1'b1, 4'd3, 6'd5, 1'b1, 32'd10, 1'b1, 32'd20, 1'b0, '0, '0, 1'b0);
        idle(1'b1);
        chk("t1_valid", 32'(exec_valid), 32'h1);
        chk("t1_op", 32'(exec_op), 32'd3);
        chk("t1_rs1", exec_rs1, 32'd10);
        chk("t1_rs2", exec_rs2, 32'd20);
        chk("t1_rd", 32'(exec_rd_tag), 32'd5);
        idle(1'b0);

        // CDB wakeup
        step(1'b1, 4'd2, 6'd7, 1'b0, 32'd9, 1'b1, 32'd1, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 6'd9, 32'hAB, 1'b0);
        chk("t2_ready", 32'(ready_int), 32'h1);
        idle(1'b1);
        chk("t2_rs1", exec_rs1, 32'hAB);

        // Younger ready op overtakes older waiting op
        step(1'b1, 4'd4, 6'd1, 1'b0, 32'd2, 1'b1, 32'd3, 1'b0, '0, '0, 1'b0);
        disp_rdy(6'd2, 1'b0);
        idle(1'b1);
        chk("t3_first", 32'(exec_rd_tag), 32'd2);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 6'd2, 32'h22, 1'b0);
        idle(1'b1);
        chk("t3_second", 32'(exec_rd_tag), 32'd1);
        chk("t3_rs1", exec_rs1, 32'h22);

        // Full queue, dropped dispatches, issue+dispatch ordering
        for (int i = 0; i < 4; i++) disp_rdy(6'(10 + i), 1'b0);
        chk("t4_full", 32'(queue_full), 32'h1);
        disp_rdy(6'd14, 1'b0);
        disp_rdy(6'd15, 1'b1);
        chk("t4_full_iss", 32'(queue_full), 32'h0);
        disp_rdy(6'd16, 1'b1);
        disp_rdy(6'd17, 1'b0);
        chk("t4_refull", 32'(queue_full), 32'h1);
        order[0] = 6'd12; order[1] = 6'd13; order[2] = 6'd16; order[3] = 6'd17;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("t4_order", 32'(exec_rd_tag), 32'(order[i]));
        end
        idle(1'b0);

        // Dispatch/CDB bypass
        step(1'b1, 4'd5, 6'd8, 1'b0, 32'd4, 1'b1, 32'd6, 1'b1, 6'd4, 32'h55, 1'b0);
        chk("t5_ready", 32'(ready_int), 32'h1);
        idle(1'b1);
        chk("t5_rs1", exec_rs1, 32'h55);

        // Reset mid-operation
        disp_rdy(6'd20, 1'b0);
        disp_rdy(6'd21, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(exec_valid), 32'h0);
        chk("mrst_ready", 32'(ready_int), 32'h0);
        chk("mrst_rs1", exec_rs1, 32'h0);
        m_q.delete();
        ev = 1'b0; eop = '0; e1 = '0; e2 = '0; erd = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0);

        // Randomized traffic, small tag space so wakeups hit often
        for (int c = 0; c < 400; c++) begin
            bit v1, v2;
            v1 = 1'($urandom_range(0, 1));
            v2 = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom),
                 v1, v1 ? $urandom : (($urandom & ~32'h3F) | $urandom_range(0, 7)),
                 v2, v2 ? $urandom : (($urandom & ~32'h3F) | $urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 2) != 0));
        end
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
